// File: rtl/tlb_lookup_stage.sv
// TLB lookup stage: registers a memory access, checks it against a direct-mapped
// tag store and runs the write-back / fill handshake with memory on a miss.
module tlb_lookup_stage #(
   parameter int addr_width         = 16,
   parameter int num_cache_lines    = 4,
   parameter int num_bytes_per_line = 32,
   parameter int tag_width          = 9
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               enable_tlb,
   input  logic [addr_width-1:0]              alu_result,
   input  logic [15:0]                        dataReg_in,
   input  logic [2:0]                         destReg_addr_input,
   input  logic                               we_input,
   input  logic [1:0]                         bp_input,
   input  logic [addr_width-1:0]              offendingAddress_in,
   input  logic [1:0]                         ldSt_enable_in,
   input  logic                               word_access_in,
   output logic [addr_width-1:0]              tlb_result,
   output logic [15:0]                        dataReg,
   output logic [2:0]                         destReg_addr_output,
   output logic                               we_output,
   output logic [1:0]                         bp_output,
   output logic [addr_width-1:0]              offendingAddress,
   output logic [1:0]                         ldSt_enable,
   output logic                               word_access_from_tlb,
   output logic                               petitionFromTlb,
   output logic [$clog2(num_cache_lines)-1:0] lineIdFromTlb,
   output logic                               writeEnableFromTlb,
   output logic                               mem_req,
   output logic                               mem_we,
   output logic [addr_width-1:0]              mem_addr,
   input  logic                               mem_ack,
   output logic                               stall
);

   localparam int offset_width = $clog2(num_bytes_per_line);
   localparam int index_width  = $clog2(num_cache_lines);

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      FILL
   } state_e;

   // Stage register
   logic [addr_width-1:0]  addr_q;
   logic [15:0]            data_q;
   logic [2:0]             dest_q;
   logic                   we_q;
   logic [1:0]             bp_q;
   logic [addr_width-1:0]  off_addr_q;
   logic [1:0]             ldst_q;
   logic                   word_q;

   // Tag store and miss FSM
   logic [num_cache_lines-1:0] valid_q;
   logic [num_cache_lines-1:0] dirty_q;
   logic [tag_width-1:0]       tag_q [num_cache_lines];
   state_e                     state_q;

   logic [index_width-1:0] index;
   logic [tag_width-1:0]   req_tag;
   logic                   hit;
   logic                   mem_access;
   logic                   miss;
   logic                   capture;
   logic                   store_hit;

   assign index      = addr_q[offset_width +: index_width];
   assign req_tag    = addr_q[addr_width-1 -: tag_width];
   assign hit        = valid_q[index] && (tag_q[index] == req_tag);
   assign mem_access = |ldst_q;
   assign miss       = mem_access && !hit;
   assign stall      = (state_q != IDLE) || miss;
   assign capture    = enable_tlb && !stall;
   assign store_hit  = ldst_q[0] && hit && enable_tlb;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q     <= '0;
         data_q     <= '0;
         dest_q     <= '0;
         we_q       <= 1'b0;
         bp_q       <= '0;
         off_addr_q <= '0;
         ldst_q     <= '0;
         word_q     <= 1'b0;
      end else if (capture) begin
         addr_q     <= alu_result;
         data_q     <= dataReg_in;
         dest_q     <= destReg_addr_input;
         we_q       <= we_input;
         bp_q       <= bp_input;
         off_addr_q <= offendingAddress_in;
         ldst_q     <= ldSt_enable_in;
         word_q     <= word_access_in;
      end
   end

   // NOTE: the tag array is a handful of flops, not a RAM; it is reset so a
   // stale tag can never match after reset, even though valid also clears.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         for (int i = 0; i < num_cache_lines; i++) begin
            tag_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (miss) begin
                  state_q <= dirty_q[index] ? WRITEBACK : FILL;
               end else if (store_hit) begin
                  dirty_q[index] <= 1'b1;
               end
            end
            WRITEBACK: begin
               if (mem_ack) begin
                  state_q <= FILL;
               end
            end
            FILL: begin
               if (mem_ack) begin
                  tag_q[index]   <= req_tag;
                  valid_q[index] <= 1'b1;
                  dirty_q[index] <= 1'b0;
                  state_q        <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default first so no path through the case
   // leaves a signal unassigned and infers a latch.
   always_comb begin
      mem_req            = 1'b0;
      mem_we             = 1'b0;
      mem_addr           = '0;
      petitionFromTlb    = 1'b0;
      writeEnableFromTlb = 1'b0;
      lineIdFromTlb      = index;
      case (state_q)
         WRITEBACK: begin
            mem_req         = 1'b1;
            mem_we          = 1'b1;
            mem_addr        = {tag_q[index], index, {offset_width{1'b0}}};
            petitionFromTlb = 1'b1;
         end
         FILL: begin
            mem_req  = 1'b1;
            mem_addr = {addr_q[addr_width-1:offset_width], {offset_width{1'b0}}};
            if (mem_ack) begin
               petitionFromTlb    = 1'b1;
               writeEnableFromTlb = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // A stalled access is shown to the cache stage as a bubble.
   assign tlb_result           = addr_q;
   assign dataReg              = data_q;
   assign destReg_addr_output  = dest_q;
   assign we_output            = we_q && !stall;
   assign bp_output            = bp_q;
   assign offendingAddress     = off_addr_q;
   assign ldSt_enable          = stall ? 2'b00 : ldst_q;
   assign word_access_from_tlb = word_q;

endmodule

// File: tb/tb_tlb_lookup_stage.sv
// Self-checking bench for tlb_lookup_stage: directed scenarios plus random accesses
// checked against a line-level model of the tag store (valid/dirty/tag per line).
module tb_tlb_lookup_stage;

   logic        clk;
   logic        reset;
   logic        enable_tlb;
   logic [15:0] alu_result;
   logic [15:0] dataReg_in;
   logic [2:0]  destReg_addr_input;
   logic        we_input;
   logic [1:0]  bp_input;
   logic [15:0] offendingAddress_in;
   logic [1:0]  ldSt_enable_in;
   logic        word_access_in;
   logic [15:0] tlb_result;
   logic [15:0] dataReg;
   logic [2:0]  destReg_addr_output;
   logic        we_output;
   logic [1:0]  bp_output;
   logic [15:0] offendingAddress;
   logic [1:0]  ldSt_enable;
   logic        word_access_from_tlb;
   logic        petitionFromTlb;
   logic [1:0]  lineIdFromTlb;
   logic        writeEnableFromTlb;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic        mem_ack;
   logic        stall;

   tlb_lookup_stage dut (
      .clk                  (clk),
      .reset                (reset),
      .enable_tlb           (enable_tlb),
      .alu_result           (alu_result),
      .dataReg_in           (dataReg_in),
      .destReg_addr_input   (destReg_addr_input),
      .we_input             (we_input),
      .bp_input             (bp_input),
      .offendingAddress_in  (offendingAddress_in),
      .ldSt_enable_in       (ldSt_enable_in),
      .word_access_in       (word_access_in),
      .tlb_result           (tlb_result),
      .dataReg              (dataReg),
      .destReg_addr_output  (destReg_addr_output),
      .we_output            (we_output),
      .bp_output            (bp_output),
      .offendingAddress     (offendingAddress),
      .ldSt_enable          (ldSt_enable),
      .word_access_from_tlb (word_access_from_tlb),
      .petitionFromTlb      (petitionFromTlb),
      .lineIdFromTlb        (lineIdFromTlb),
      .writeEnableFromTlb   (writeEnableFromTlb),
      .mem_req              (mem_req),
      .mem_we               (mem_we),
      .mem_addr             (mem_addr),
      .mem_ack              (mem_ack),
      .stall                (stall)
   );

   int n_asserts = 0;
   int n_fail    = 0;
   int dut_misses = 0;

   // Reference model: one entry per cache line
   bit         m_valid [4];
   bit         m_dirty [4];
   logic [8:0] m_tag   [4];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #2;
   endtask

   task automatic bubble();
      enable_tlb     = 1'b1;
      ldSt_enable_in = 2'b00;
      we_input       = 1'b0;
      alu_result     = 16'($urandom);
   endtask

   task automatic model_clear();
      for (int i = 0; i < 4; i++) begin
         m_valid[i] = 1'b0;
         m_dirty[i] = 1'b0;
         m_tag[i]   = '0;
      end
   endtask

   // Presents one instruction mid-cycle (stall must be 0), then follows it through
   // lookup, optional write-back, fill and replay. Returns mid-cycle with stall=0.
   task automatic access(input logic [15:0] addr, input logic [1:0] ldst, input logic we_in,
                         input int wb_lat, input int fill_lat, input bit hold_alu);
      logic [15:0] data, off;
      logic [2:0]  dst;
      logic [1:0]  bp;
      logic        wa;
      int          idx;
      logic [8:0]  tg;
      bit          hit_m, dirty_m;
      data = 16'($urandom); off = 16'($urandom);
      dst  = 3'($urandom);  bp  = 2'($urandom); wa = 1'($urandom);
      enable_tlb = 1'b1; alu_result = addr; ldSt_enable_in = ldst; we_input = we_in;
      dataReg_in = data; destReg_addr_input = dst; bp_input = bp;
      offendingAddress_in = off; word_access_in = wa;
      next();
      if (hold_alu) begin
         enable_tlb = 1'b1; ldSt_enable_in = 2'b00; we_input = 1'b1;
         destReg_addr_input = 3'd5; alu_result = 16'h1234;
      end else begin
         bubble();
      end
      #1;
      idx     = int'(addr[6:5]);
      tg      = addr[15:7];
      hit_m   = (ldst == 2'b00) || (m_valid[idx] && m_tag[idx] == tg);
      dirty_m = m_dirty[idx];
      chk("fwd_addr", tlb_result, addr);
      chk("fwd_data", dataReg, data);
      chk("fwd_dest", destReg_addr_output, dst);
      chk("fwd_bp", bp_output, bp);
      chk("fwd_offending", offendingAddress, off);
      chk("fwd_word", word_access_from_tlb, wa);
      chk("lookup_stall", stall, !hit_m);
      chk("lookup_no_req", mem_req, 1'b0);
      if (stall) dut_misses++;
      if (!hit_m) begin
         chk("miss_bubble_ldst", ldSt_enable, 2'b00);
         chk("miss_bubble_we", we_output, 1'b0);
         next();
         if (dirty_m) begin
            for (int c = 0; c <= wb_lat; c++) begin
               enable_tlb = 1'($urandom);
               mem_ack = (c == wb_lat);
               #1;
               chk("wb_req", mem_req, 1'b1);
               chk("wb_we", mem_we, 1'b1);
               chk("wb_addr", mem_addr, {m_tag[idx], addr[6:5], 5'b0});
               chk("wb_petition", petitionFromTlb, 1'b1);
               chk("wb_wen", writeEnableFromTlb, 1'b0);
               chk("wb_line", lineIdFromTlb, addr[6:5]);
               chk("wb_stall", stall, 1'b1);
               chk("wb_bubble", ldSt_enable, 2'b00);
               next();
            end
         end
         for (int c = 0; c <= fill_lat; c++) begin
            enable_tlb = 1'($urandom);
            mem_ack = (c == fill_lat);
            #1;
            chk("fill_req", mem_req, 1'b1);
            chk("fill_we", mem_we, 1'b0);
            chk("fill_addr", mem_addr, {addr[15:5], 5'b0});
            chk("fill_petition", petitionFromTlb, mem_ack);
            chk("fill_wen", writeEnableFromTlb, mem_ack);
            if (mem_ack) chk("fill_line", lineIdFromTlb, addr[6:5]);
            chk("fill_stall", stall, 1'b1);
            chk("fill_bubble_we", we_output, 1'b0);
            next();
         end
         mem_ack    = 1'b0;
         enable_tlb = 1'b1;
         #1;
         m_tag[idx]   = tg;
         m_valid[idx] = 1'b1;
         m_dirty[idx] = 1'b0;
         chk("replay_stall", stall, 1'b0);
         chk("replay_ldst", ldSt_enable, ldst);
         chk("replay_we", we_output, we_in);
         chk("replay_no_req", mem_req, 1'b0);
         chk("replay_addr", tlb_result, addr);
      end else begin
         chk("hit_ldst", ldSt_enable, ldst);
         chk("hit_we", we_output, we_in);
      end
      if (ldst[0]) m_dirty[idx] = 1'b1;
   endtask

   initial begin
      model_clear();
      reset = 1'b0; mem_ack = 1'b1; enable_tlb = 1'b1;
      alu_result = 16'hFFFF; dataReg_in = 16'hAAAA; destReg_addr_input = 3'd7;
      we_input = 1'b1; bp_input = 2'b11; offendingAddress_in = 16'h5555;
      ldSt_enable_in = 2'b10; word_access_in = 1'b1;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_tlb_result", tlb_result, 16'h0);
      chk("rst_dataReg", dataReg, 16'h0);
      chk("rst_we_output", we_output, 1'b0);
      chk("rst_ldst", ldSt_enable, 2'b00);
      chk("rst_stall", stall, 1'b0);
      chk("rst_mem_req", mem_req, 1'b0);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 16'h0);
      chk("rst_petition", petitionFromTlb, 1'b0);
      chk("rst_wen", writeEnableFromTlb, 1'b0);
      mem_ack = 1'b0;
      bubble();
      reset = 1'b1;
      next();
      #1;
      chk("post_rst_stall", stall, 1'b0);
      chk("post_rst_req", mem_req, 1'b0);

      // Clean miss at 0x0040, ack three cycles into FILL
      access(16'h0040, 2'b10, 1'b0, 0, 2, 1'b0);
      // Store hit dirties line 2, then a conflicting load forces a write-back
      access(16'h0044, 2'b01, 1'b0, 0, 0, 1'b0);
      access(16'h0140, 2'b10, 1'b0, 1, 1, 1'b0);
      // Line 2 must now be clean: reloading 0x0040 fills without write-back
      access(16'h0040, 2'b10, 1'b0, 0, 0, 1'b0);

      // ALU write held behind a miss, forwarded exactly once afterwards
      access(16'h0360, 2'b10, 1'b0, 0, 2, 1'b1);
      next();
      bubble();
      #1;
      chk("alu_fwd_we", we_output, 1'b1);
      chk("alu_fwd_dest", destReg_addr_output, 3'd5);
      chk("alu_fwd_stall", stall, 1'b0);
      next();
      #1;
      chk("alu_once_we", we_output, 1'b0);

      // Reset asserted in FILL aborts the transfer at once
      alu_result = 16'h0260; ldSt_enable_in = 2'b10; we_input = 1'b0; enable_tlb = 1'b1;
      next();
      bubble();
      #1;
      chk("abort_miss_stall", stall, 1'b1);
      next();
      #1;
      chk("abort_fill_req", mem_req, 1'b1);
      next();
      reset = 1'b0;
      #1;
      chk("abort_req_drop", mem_req, 1'b0);
      chk("abort_stall", stall, 1'b0);
      chk("abort_petition", petitionFromTlb, 1'b0);
      chk("abort_tlb_result", tlb_result, 16'h0);
      next();
      reset = 1'b1;
      model_clear();
      #1;
      access(16'h0260, 2'b10, 1'b0, 0, 0, 1'b0);

      // Four lines filled once, then all hit
      dut_misses = 0;
      for (int i = 0; i < 4; i++) access({9'd7, 2'(i), 5'h03}, 2'b10, 1'b0, 0, i, 1'b0);
      chk("four_fills", dut_misses, 4);
      dut_misses = 0;
      for (int i = 0; i < 4; i++) access({9'd7, 2'(i), 5'h03}, 2'b10, 1'b0, 0, 0, 1'b0);
      chk("refetch_no_stalls", dut_misses, 0);

      // mem_ack in IDLE, with the stage held, changes nothing
      enable_tlb = 1'b0; alu_result = 16'hBEEF; ldSt_enable_in = 2'b01; mem_ack = 1'b1;
      #1;
      chk("idle_ack_petition", petitionFromTlb, 1'b0);
      chk("idle_ack_wen", writeEnableFromTlb, 1'b0);
      chk("idle_ack_req", mem_req, 1'b0);
      next();
      mem_ack = 1'b0;
      #1;
      chk("idle_ack_stall", stall, 1'b0);
      chk("hold_addr", tlb_result, 16'h03E3);
      chk("hold_ldst", ldSt_enable, 2'b10);
      bubble();
      access(16'h03E3, 2'b10, 1'b0, 0, 0, 1'b0);

      // Random accesses over a small tag pool
      for (int n = 0; n < 60; n++) begin
         logic [15:0] a;
         logic [1:0]  ls;
         a  = {9'($urandom_range(0, 3)), 2'($urandom), 5'($urandom)};
         ls = 2'($urandom_range(0, 2));
         access(a, ls, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
